// File: rtl/twos_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module      : twos_ser_tx
//  Description : Parallel-to-serial transmitter feeding a serial two's
//                complement inverter. Accepts a W-bit word over a
//                valid/ready handshake, emits one frame-reset cycle on ser_r,
//                then shifts the word out LSB first on ser_i.
//                Optional feature macro: TWOS_SER_TX_SIGN_EXT_EN
//                (appends the sign bit as an extra (W+1)-th serial bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module twos_ser_tx #(
   parameter int W = 8
) (
   input  logic         t_clk,
   input  logic         r,
   input  logic         ld_valid,
   input  logic [W-1:0] ld_data,
   output logic         ld_ready,
   output logic         ser_i,
   output logic         ser_r,
   output logic         busy,
   output logic         done
);

   // Frame length: one extra sign bit when the extension feature is built in
`ifdef TWOS_SER_TX_SIGN_EXT_EN
   localparam int c_nbits = W + 1;
`else
   localparam int c_nbits = W;
`endif

   // Counter is sized to hold N, even though it only ever reaches N-1
   localparam int                c_cw   = $clog2(c_nbits + 1);
   localparam logic [c_cw-1:0]   c_last = c_cw'(c_nbits - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SYNC  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   logic [c_nbits-1:0]   r_shreg;
   logic [c_cw-1:0]      r_cnt;
   logic                 r_ld_ready;
   logic                 r_ser_i;
   logic                 r_ser_r;
   logic                 r_busy;
   logic                 r_done;

   // A transfer can only happen while idle; ready is a registered copy of that
   wire w_xfer = ld_valid && (r_state == S_IDLE);

   // Word captured at transfer time; extension bit replicated from the MSB
   wire [c_nbits-1:0] w_load_word;
`ifdef TWOS_SER_TX_SIGN_EXT_EN
   assign w_load_word = {ld_data[W-1], ld_data};
`else
   assign w_load_word = ld_data;
`endif

   // Frame sequencer: state, shift register, bit counter and registered outputs
   always_ff @(posedge t_clk or posedge r) begin
      if (r) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_cnt      <= '0;
         r_ld_ready <= 1'b1;
         r_ser_i    <= 1'b0;
         r_ser_r    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_state    <= S_SYNC;
                  r_shreg    <= w_load_word;
                  r_cnt      <= '0;
                  r_ld_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  // Downstream stays in reset for the SYNC cycle
                  r_ser_r    <= 1'b1;
                  r_ser_i    <= 1'b0;
               end
            end

            S_SYNC: begin
               r_state <= S_SHIFT;
               r_ser_r <= 1'b0;
               // Bit 0 appears the cycle after SYNC
               r_ser_i <= r_shreg[0];
            end

            S_SHIFT: begin
               r_shreg <= {1'b0, r_shreg[c_nbits-1:1]};
               if (r_cnt == c_last) begin
                  // Last bit has been presented; counter holds at N-1
                  r_state <= S_DONE;
                  r_ser_i <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  // Present the next bit in the same edge that shifts it down
                  r_ser_i <= r_shreg[1];
               end
            end

            S_DONE: begin
               r_state    <= S_IDLE;
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_ld_ready <= 1'b1;
               r_ser_r    <= 1'b1;
               r_ser_i    <= 1'b0;
            end

            default: begin
               r_state    <= S_IDLE;
               r_cnt      <= '0;
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_ld_ready <= 1'b1;
               r_ser_r    <= 1'b1;
               r_ser_i    <= 1'b0;
            end
         endcase
      end
   end

   assign ld_ready = r_ld_ready;
   assign ser_i    = r_ser_i;
   assign ser_r    = r_ser_r;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_twos_ser_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twos_ser_tx
//  Description : Scoreboard bench for twos_ser_tx. A reference model predicts
//                transfers and expected serial frames; a monitor collects the
//                serial stream and compares it when done is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twos_ser_tx;

   localparam int W = 8;
`ifdef TWOS_SER_TX_SIGN_EXT_EN
   localparam int N = W + 1;
`else
   localparam int N = W;
`endif

   logic         t_clk;
   logic         r;
   logic         ld_valid;
   logic [W-1:0] ld_data;
   logic         ld_ready;
   logic         ser_i;
   logic         ser_r;
   logic         busy;
   logic         done;

   twos_ser_tx #(.W(W)) dut (
      .t_clk    (t_clk),
      .r        (r),
      .ld_valid (ld_valid),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .ser_i    (ser_i),
      .ser_r    (ser_r),
      .busy     (busy),
      .done     (done)
   );

   initial t_clk = 1'b0;
   always #5 t_clk = ~t_clk;

   typedef struct {
      logic [W:0] bits;
      int         k;
   } frame_t;

   frame_t q[$];
   int     cyc     = 0;
   int     m_free  = 0;
   int     n_xfer  = 0;
   int     n_chk   = 0;
   int     n_fail  = 0;
   logic [W:0] col;
   int     ncol    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, cyc);
      end
   endtask

   // Frame content from the word value: bit n of the word, plus the sign bit
   function automatic logic [W:0] ref_bits(input logic [W-1:0] d);
      longint v;
      v = longint'(d);
`ifdef TWOS_SER_TX_SIGN_EXT_EN
      if (d[W-1]) v = v + (longint'(1) << W);
`endif
      return (W+1)'(v);
   endfunction

   // Reference model: one word per N+3 edges, no transfer while in reset
   always @(posedge t_clk) begin
      frame_t f;
      cyc = cyc + 1;
      if (r) begin
         m_free = cyc + 1;
      end else if (ld_valid && cyc >= m_free) begin
         f.bits = ref_bits(ld_data);
         f.k    = cyc;
         q.push_back(f);
         m_free = cyc + N + 3;
         n_xfer = n_xfer + 1;
      end
   end

   // A reset discards any frame in flight
   always @(posedge r) q.delete();

   // Monitor: per-cycle handshake checks, serial collection, compare on done
   always @(negedge t_clk) begin
      frame_t e;
      logic   exp_idle;
      if (r) begin
         ncol = 0;
         col  = '0;
         chk("rst_ld_ready", 64'(ld_ready), 64'd1);
         chk("rst_ser_r",    64'(ser_r),    64'd1);
         chk("rst_ser_i",    64'(ser_i),    64'd0);
         chk("rst_busy",     64'(busy),     64'd0);
         chk("rst_done",     64'(done),     64'd0);
      end else begin
         exp_idle = (cyc + 1 >= m_free);
         chk("ld_ready", 64'(ld_ready), 64'(exp_idle));
         chk("busy",     64'(busy),     64'(!exp_idle));
         if (done) begin
            chk("done_ser_r", 64'(ser_r), 64'd0);
            chk("done_ser_i", 64'(ser_i), 64'd0);
            if (q.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               e = q.pop_front();
               chk("frame_len",   64'(ncol), 64'(N));
               chk("frame_bits",  64'(col),  64'(e.bits));
               chk("done_timing", 64'(cyc),  64'(e.k + N + 1));
            end
            ncol = 0;
            col  = '0;
         end else if (!ser_r) begin
            if (ncol < N) col[ncol] = ser_i;
            ncol = ncol + 1;
         end else begin
            chk("idle_ser_i", 64'(ser_i), 64'd0);
         end
      end
   end

   // Advance one edge, then settle inputs 1 time unit later
   task automatic step();
      @(posedge t_clk);
      #1;
   endtask

   // Present a word and hold valid until the model records its transfer
   task automatic send(input logic [W-1:0] d, input bit drop_valid);
      int start;
      int t;
      start    = n_xfer;
      ld_data  = d;
      ld_valid = 1'b1;
      t = 0;
      while (n_xfer == start && t < 200) begin
         step();
         t++;
      end
      if (n_xfer == start) chk("send_timeout", 64'd1, 64'd0);
      if (drop_valid) ld_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q.size() != 0 || cyc + 1 < m_free) && t < 200) begin
         step();
         t++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      r        = 1'b1;
      ld_valid = 1'b1;
      ld_data  = 8'h05;
      // Reset held 3 cycles with valid high: no transfer may occur
      repeat (3) step();
      chk("no_xfer_in_reset", 64'(n_xfer), 64'd0);
      // Release with valid still high: transfer on the next edge
      r = 1'b0;
      send(8'h05, 1'b1);
      drain();

      // Sign-extension corner (and a normal word in the default build)
      send(8'h80, 1'b1);
      drain();

      // Back-to-back with valid held
      send(8'h3C, 1'b0);
      send(8'hA1, 1'b1);
      drain();

      // Load attempts while busy must not disturb the captured word
      send(8'hFF, 1'b0);
      ld_data = 8'h00;
      repeat (5) step();
      ld_valid = 1'b0;
      drain();

      // Abort after three bits of 8'hAA
      send(8'hAA, 1'b1);
      repeat (4) step();
      r = 1'b1;
      #1;
      chk("abort_ser_r",    64'(ser_r),    64'd1);
      chk("abort_ser_i",    64'(ser_i),    64'd0);
      chk("abort_busy",     64'(busy),     64'd0);
      chk("abort_done",     64'(done),     64'd0);
      chk("abort_ld_ready", 64'(ld_ready), 64'd1);
      repeat (2) step();
      r = 1'b0;
      send(8'h01, 1'b1);
      drain();

      // Randomized traffic with random valid gaps
      for (int i = 0; i < 60; i++) begin
         ld_data  = W'($urandom);
         ld_valid = ($urandom_range(0, 3) != 0);
         step();
      end
      ld_valid = 1'b0;
      drain();
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
